// File: rtl/usb_pkg.sv
// Shared definitions for the USB send arbiter: bag-type codes, FSM encoding
// and the default requester count.
package usb_pkg;

    localparam int REQ_NUM_DEF = 4;

    localparam logic [3:0] BAG_INIT  = 4'b0000;
    localparam logic [3:0] BAG_SETUP = 4'b0001;
    localparam logic [3:0] BAG_DATA  = 4'b0010;
    localparam logic [3:0] BAG_ACK   = 4'b0011;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ARB  = 3'd1,
        ST_SEND = 3'd2,
        ST_RLS  = 3'd3,
        ST_RTRY = 3'd4,
        ST_DONE = 3'd5
    } arb_state_e;

endpackage

// File: rtl/usb_arb_pick.sv
// Combinational requester picker: first set request found scanning upward
// (mod 4) from the start pointer.
module usb_arb_pick (
    input  logic [3:0] req_i,
    input  logic [1:0] start_i,
    output logic [1:0] idx_o,
    output logic       vld_o
);

    logic [1:0] cand;

    // Scan from the farthest offset down so the nearest request wins last.
    always_comb begin
        idx_o = 2'd0;
        vld_o = 1'b0;
        cand  = 2'd0;
        for (int k = 3; k >= 0; k--) begin
            cand = start_i + 2'(k);
            if (req_i[cand]) begin
                idx_o = cand;
                vld_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/usb_send_arb.sv
// Send arbiter: grants one of four requesters to the link controller, retries
// failed sends. Define USB_ARB_RR_EN for round-robin, otherwise fixed priority.
module usb_send_arb
    import usb_pkg::*;
#(
    parameter int REQ_NUM   = REQ_NUM_DEF,
    parameter int RETRY_MAX = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [REQ_NUM-1:0]   req_fs,
    input  logic [4*REQ_NUM-1:0] req_btype,
    output logic [REQ_NUM-1:0]   req_fd,
    output logic [REQ_NUM-1:0]   req_ff,
    output logic [1:0]           grant_idx,
    output logic                 grant_vld,
    output logic                 fs_send,
    output logic [3:0]           send_btype,
    input  logic                 fd_send,
    input  logic                 ff_send
);

    arb_state_e         state_q;
    logic [1:0]         grant_idx_q;
    logic               grant_vld_q;
    logic               fs_send_q;
    logic [3:0]         send_btype_q;
    logic [REQ_NUM-1:0] req_fd_q;
    logic [REQ_NUM-1:0] req_ff_q;
    logic [3:0]         retry_cnt_q;
    logic               fail_q;

    logic [1:0] pick_start;
    logic [1:0] pick_idx;
    logic       pick_vld;
    logic       retry_more;

`ifdef USB_ARB_RR_EN
    logic [1:0] ptr_q;
    assign pick_start = ptr_q;
`else
    assign pick_start = 2'd0;
`endif

    usb_arb_pick u_pick (
        .req_i   (req_fs),
        .start_i (pick_start),
        .idx_o   (pick_idx),
        .vld_o   (pick_vld)
    );

    assign retry_more = ({1'b0, retry_cnt_q} + 5'd1) < 5'(RETRY_MAX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            grant_idx_q  <= 2'd0;
            grant_vld_q  <= 1'b0;
            fs_send_q    <= 1'b0;
            send_btype_q <= BAG_INIT;
            req_fd_q     <= '0;
            req_ff_q     <= '0;
            retry_cnt_q  <= 4'd0;
            fail_q       <= 1'b0;
`ifdef USB_ARB_RR_EN
            ptr_q        <= 2'd0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: state_q <= ST_ARB;
                ST_ARB: begin
                    if (pick_vld) begin
                        grant_idx_q  <= pick_idx;
                        send_btype_q <= req_btype[{pick_idx, 2'b00} +: 4];
                        retry_cnt_q  <= 4'd0;
                        grant_vld_q  <= 1'b1;
                        state_q      <= ST_SEND;
                    end
                end
                // fs_send only rises once the link shows fd_send low.
                ST_SEND: begin
                    if (fd_send) begin
                        fs_send_q <= 1'b0;
                        if (ff_send && retry_more) begin
                            retry_cnt_q <= retry_cnt_q + 4'd1;
                            state_q     <= ST_RTRY;
                        end else begin
                            fail_q  <= ff_send;
                            state_q <= ST_RLS;
                        end
                    end else begin
                        fs_send_q <= 1'b1;
                    end
                end
                ST_RTRY: if (!fd_send) state_q <= ST_SEND;
                ST_RLS: begin
                    if (!fd_send) begin
                        req_fd_q[grant_idx_q] <= 1'b1;
                        req_ff_q[grant_idx_q] <= fail_q;
                        state_q               <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (!req_fs[grant_idx_q]) begin
                        req_fd_q    <= '0;
                        req_ff_q    <= '0;
                        grant_vld_q <= 1'b0;
`ifdef USB_ARB_RR_EN
                        ptr_q       <= grant_idx_q + 2'd1;
`endif
                        state_q     <= ST_ARB;
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    grant_vld_q <= 1'b0;
                    fs_send_q   <= 1'b0;
                    req_fd_q    <= '0;
                    req_ff_q    <= '0;
                end
            endcase
        end
    end

    assign grant_idx  = grant_idx_q;
    assign grant_vld  = grant_vld_q;
    assign fs_send    = fs_send_q;
    assign send_btype = send_btype_q;
    assign req_fd     = req_fd_q;
    assign req_ff     = req_ff_q;

endmodule

// File: tb/tb_usb_send_arb.sv
// Bench for usb_send_arb with a behavioural link responder and a reference
// model of grant choice, attempt count and fail outcome.
module tb_usb_send_arb;

    localparam int RMAX = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_fs;
    logic [15:0] req_btype;
    logic [3:0]  req_fd;
    logic [3:0]  req_ff;
    logic [1:0]  grant_idx;
    logic        grant_vld;
    logic        fs_send;
    logic [3:0]  send_btype;
    logic        fd_send;
    logic        ff_send;

    int total = 0;
    int bad   = 0;
    int pulses;
    int viol;
    int resp_delay  = 0;
    int hold_cycles = 0;
    int exp_ptr     = 0;
    bit fail_seq[$];

    always #5 clk = ~clk;

    usb_send_arb #(.REQ_NUM(4), .RETRY_MAX(RMAX)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_fs     (req_fs),
        .req_btype  (req_btype),
        .req_fd     (req_fd),
        .req_ff     (req_ff),
        .grant_idx  (grant_idx),
        .grant_vld  (grant_vld),
        .fs_send    (fs_send),
        .send_btype (send_btype),
        .fd_send    (fd_send),
        .ff_send    (ff_send)
    );

    // Monitor: counts fs_send rising edges and protocol violations.
    initial begin
        bit prev_fs;
        prev_fs = 1'b0;
        pulses  = 0;
        viol    = 0;
        forever begin
            @(posedge clk);
            #1;
            if (fs_send === 1'b1 && !prev_fs) pulses++;
            if (fs_send === 1'b1 && (fd_send || !grant_vld)) viol++;
            prev_fs = (fs_send === 1'b1);
        end
    end

    // Link responder: answers each fs_send after resp_delay, holds fd_send
    // for hold_cycles after fs_send drops.
    initial begin
        int lw;
        int lh;
        lw = 0;
        lh = 0;
        fd_send = 1'b0;
        ff_send = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                fd_send = 1'b0;
                ff_send = 1'b0;
                lw = 0;
            end else if (!fd_send) begin
                if (fs_send) begin
                    if (lw >= resp_delay) begin
                        fd_send = 1'b1;
                        ff_send = (fail_seq.size() > 0) ? fail_seq.pop_front() : 1'b0;
                        lh = hold_cycles;
                        lw = 0;
                    end else begin
                        lw++;
                    end
                end else begin
                    lw = 0;
                end
            end else if (!fs_send) begin
                if (lh > 0) lh--;
                else begin
                    fd_send = 1'b0;
                    ff_send = 1'b0;
                end
            end
        end
    end

    function automatic int pick(input logic [3:0] m, input int start);
        for (int k = 0; k < 4; k++) begin
            int i;
            i = (start + k) % 4;
            if (m[i]) return i;
        end
        return -1;
    endfunction

    task automatic run_txn(input logic [3:0] mask, input logic [15:0] bt, input int nfail,
                           input bit keep, input bit chk_lat, input string tag);
        int w, exp_att, base_p, base_v, cyc, start;
        bit exp_fail;
        logic [3:0] exp_bt, one, exp_fd, exp_ff;
`ifdef USB_ARB_RR_EN
        start = exp_ptr;
`else
        start = 0;
`endif
        w        = pick(mask, start);
        exp_fail = (nfail >= RMAX);
        exp_att  = exp_fail ? RMAX : nfail + 1;
        exp_bt   = bt[w*4 +: 4];
        one      = 4'b0001;
        exp_fd   = one << w;
        exp_ff   = exp_fail ? exp_fd : 4'b0000;
        fail_seq.delete();
        for (int k = 0; k < exp_att; k++) fail_seq.push_back(k < nfail);
        base_p = pulses;
        base_v = viol;
        @(negedge clk);
        req_btype = bt;
        req_fs    = mask;
        if (chk_lat) begin
            cyc = 0;
            while (fs_send !== 1'b1 && cyc < 10) begin
                @(posedge clk); #1; cyc++;
            end
            total++;
            if (cyc !== 2) begin
                bad++;
                $display("FAIL %s latency: got %0d cycles, expected 2", tag, cyc);
            end
        end
        cyc = 0;
        while (req_fd === 4'b0000 && cyc < 1000) begin
            @(posedge clk); #1; cyc++;
        end
        total++;
        if (req_fd !== exp_fd) begin
            bad++;
            $display("FAIL %s req_fd: got %b, expected %b", tag, req_fd, exp_fd);
        end
        total++;
        if (req_ff !== exp_ff) begin
            bad++;
            $display("FAIL %s req_ff: got %b, expected %b", tag, req_ff, exp_ff);
        end
        total++;
        if (grant_idx !== 2'(w)) begin
            bad++;
            $display("FAIL %s grant_idx: got %0d, expected %0d", tag, grant_idx, w);
        end
        total++;
        if (send_btype !== exp_bt) begin
            bad++;
            $display("FAIL %s send_btype: got %b, expected %b", tag, send_btype, exp_bt);
        end
        total++;
        if (grant_vld !== 1'b1) begin
            bad++;
            $display("FAIL %s grant_vld at done: got %b, expected 1", tag, grant_vld);
        end
        total++;
        if (pulses - base_p !== exp_att) begin
            bad++;
            $display("FAIL %s fs_send pulses: got %0d, expected %0d", tag, pulses - base_p, exp_att);
        end
        @(negedge clk);
        req_fs = keep ? (mask & ~exp_fd) : 4'b0000;
        cyc = 0;
        while (req_fd !== 4'b0000 && cyc < 50) begin
            @(posedge clk); #1; cyc++;
        end
        total++;
        if (grant_vld !== 1'b0 || req_fd !== 4'b0000) begin
            bad++;
            $display("FAIL %s release: got grant_vld=%b req_fd=%b, expected 0/0000", tag, grant_vld, req_fd);
        end
        total++;
        if (viol - base_v !== 0) begin
            bad++;
            $display("FAIL %s protocol: got %0d fs_send violations, expected 0", tag, viol - base_v);
        end
        exp_ptr = (w + 1) % 4;
        if (keep) begin
            @(negedge clk);
            req_fs = mask;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req_fs = 4'b0000;
        req_btype = 16'h0000;
        repeat (3) @(negedge clk);
        total++;
        if ({fs_send, grant_vld, req_fd, req_ff, grant_idx, send_btype} !== 15'd0) begin
            bad++;
            $display("FAIL reset_hold: got fs=%b gv=%b fd=%b ff=%b gi=%0d bt=%b, expected all 0",
                     fs_send, grant_vld, req_fd, req_ff, grant_idx, send_btype);
        end
        rst = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if ({fs_send, grant_vld, req_fd, req_ff} !== 10'd0) begin
            bad++;
            $display("FAIL reset_release: got fs=%b gv=%b fd=%b ff=%b, expected all 0",
                     fs_send, grant_vld, req_fd, req_ff);
        end
        exp_ptr = 0;
    endtask

    task automatic test_single();
        resp_delay = 1; hold_cycles = 0;
        run_txn(4'b0100, 16'h0D00, 0, 1'b0, 1'b1, "single");
    endtask

    task automatic test_retry_fail();
        resp_delay = 0; hold_cycles = 0;
        run_txn(4'b0010, 16'h00A0, RMAX, 1'b0, 1'b1, "retry_fail");
    endtask

    task automatic test_fail_pass();
        resp_delay = 2; hold_cycles = 1;
        run_txn(4'b1000, 16'h7000, 1, 1'b0, 1'b1, "fail_pass");
    endtask

    task automatic test_fd_hold();
        resp_delay = 0; hold_cycles = 5;
        run_txn(4'b0001, 16'h0003, 1, 1'b0, 1'b1, "hold_rtry");
        run_txn(4'b0001, 16'h0005, RMAX, 1'b0, 1'b1, "hold_rtry_fail");
        run_txn(4'b0100, 16'h0600, 0, 1'b0, 1'b1, "hold_rls");
        hold_cycles = 0;
    endtask

    task automatic test_priority();
        resp_delay = 0; hold_cycles = 0;
        for (int n = 0; n < 5; n++)
            run_txn(4'b1111, 16'h4321, 0, 1'b1, (n == 0), "priority");
        @(negedge clk);
        req_fs = 4'b0000;
        repeat (4) @(negedge clk);
        // Drain any grant picked up by the re-raised requests.
        while (grant_vld === 1'b1 && req_fd === 4'b0000) @(negedge clk);
        repeat (4) @(negedge clk);
    endtask

    task automatic test_mid_reset();
        int cyc;
        resp_delay = 0; hold_cycles = 0;
        run_txn(4'b0010, 16'h0010, 0, 1'b0, 1'b1, "pre_abort");
        resp_delay = 1000;
        @(negedge clk);
        req_btype = 16'h0900;
        req_fs = 4'b0100;
        cyc = 0;
        while (fs_send !== 1'b1 && cyc < 20) begin
            @(posedge clk); #1; cyc++;
        end
        total++;
        if (fs_send !== 1'b1) begin
            bad++;
            $display("FAIL abort_send: got fs_send=%b, expected 1", fs_send);
        end
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        total++;
        if ({fs_send, grant_vld, req_fd, req_ff, grant_idx, send_btype} !== 15'd0) begin
            bad++;
            $display("FAIL async_reset: got fs=%b gv=%b fd=%b ff=%b gi=%0d bt=%b, expected all 0",
                     fs_send, grant_vld, req_fd, req_ff, grant_idx, send_btype);
        end
        req_fs = 4'b0000;
        resp_delay = 0;
        fail_seq.delete();
        exp_ptr = 0;
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        total++;
        if (req_fd !== 4'b0000) begin
            bad++;
            $display("FAIL abort_no_done: got req_fd=%b, expected 0000", req_fd);
        end
        run_txn(4'b1111, 16'hCAFE, 0, 1'b0, 1'b1, "after_reset");
    endtask

    task automatic test_random();
        for (int n = 0; n < 25; n++) begin
            resp_delay  = $urandom_range(0, 3);
            hold_cycles = $urandom_range(0, 3);
            run_txn(4'($urandom_range(1, 15)), 16'($urandom), $urandom_range(0, 4),
                    1'b0, 1'b1, "random");
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_retry_fail();
        test_fail_pass();
        test_fd_hold();
        test_mid_reset();
        test_random();
        test_priority();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
